// File: rtl/mc_path_feeder.sv
// Path sequencer for the Monte Carlo core: stores N_DAY days of N_PATH samples and
// streams each day N_PASS times over valid/ready, advancing on the core's resend pulse.
module mc_path_feeder #(
   parameter int DATA_W = 12,
   parameter int N_PATH = 256,
   parameter int N_DAY  = 8,
   parameter int N_PASS = 2,
   localparam int AW = $clog2(N_PATH * N_DAY),
   localparam int DW = (N_DAY > 1) ? $clog2(N_DAY) : 1,
   localparam int PW = (N_PASS > 1) ? $clog2(N_PASS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_en,
   input  logic [AW-1:0]     load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic              start,
   input  logic              resend,
   input  logic              path_ready,
   output logic              path_valid,
   output logic [DATA_W-1:0] path,
   output logic [DW-1:0]     day_idx,
   output logic [PW-1:0]     pass_idx,
   output logic              busy,
   output logic              done
);

   localparam int DEPTH = N_PATH * N_DAY;
   localparam int SW    = $clog2(N_PATH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_WAIT
   } state_t;

   state_t            r_state;
   logic [SW-1:0]     r_sample;
   logic [DW-1:0]     r_day;
   logic [PW-1:0]     r_pass;
   logic              r_done;
   logic [DATA_W-1:0] r_mem [DEPTH];

   state_t            w_next_state;
   logic [SW-1:0]     w_next_sample;
   logic [DW-1:0]     w_next_day;
   logic [PW-1:0]     w_next_pass;
   logic              w_next_done;
   logic [AW-1:0]     w_rd_addr;
   logic              w_wr_en;

   // Storage is only writable while idle so a running stream never sees its data change.
   assign w_wr_en = load_en && (r_state == S_IDLE) &&
                    ({1'b0, load_addr} < (AW+1)'(DEPTH));

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[load_addr] <= load_data;
      end
   end

   assign w_rd_addr = AW'(32'(r_day) * N_PATH + 32'(r_sample));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_sample <= '0;
         r_day    <= '0;
         r_pass   <= '0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_sample <= w_next_sample;
         r_day    <= w_next_day;
         r_pass   <= w_next_pass;
         r_done   <= w_next_done;
      end
   end

   always_comb begin
      w_next_state  = r_state;
      w_next_sample = r_sample;
      w_next_day    = r_day;
      w_next_pass   = r_pass;
      w_next_done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next_state  = S_STREAM;
               w_next_sample = '0;
               w_next_day    = '0;
               w_next_pass   = '0;
            end
         end
         S_STREAM: begin
            if (path_ready) begin
               if (r_sample == SW'(N_PATH - 1)) begin
                  w_next_state  = S_WAIT;
                  w_next_sample = '0;
               end else begin
                  w_next_sample = r_sample + SW'(1);
               end
            end
         end
         S_WAIT: begin
            // Replay the same day until its last pass, then move on; the last day ends the run.
            if (resend) begin
               if (r_pass != PW'(N_PASS - 1)) begin
                  w_next_pass  = r_pass + PW'(1);
                  w_next_state = S_STREAM;
               end else if (r_day != DW'(N_DAY - 1)) begin
                  w_next_pass  = '0;
                  w_next_day   = r_day + DW'(1);
                  w_next_state = S_STREAM;
               end else begin
                  w_next_pass  = '0;
                  w_next_day   = '0;
                  w_next_done  = 1'b1;
                  w_next_state = S_IDLE;
               end
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_comb begin
      path = '0;
      if (r_state == S_STREAM) begin
         path = r_mem[w_rd_addr];
      end
   end

   assign path_valid = (r_state == S_STREAM);
   assign busy       = (r_state != S_IDLE);
   assign day_idx    = r_day;
   assign pass_idx   = r_pass;
   assign done       = r_done;

endmodule

// File: tb/tb_mc_path_feeder.sv
// Directed bench for mc_path_feeder with storage loaded as mem[a] = a; each task
// drives one scenario and checks the stream against hand-derived sample values.
module tb_mc_path_feeder;

   localparam int DATA_W = 12;
   localparam int N_PATH = 256;
   localparam int N_DAY  = 8;
   localparam int N_PASS = 2;
   localparam int AW     = 11;
   localparam int DW     = 3;
   localparam int PW     = 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              load_en;
   logic [AW-1:0]     load_addr;
   logic [DATA_W-1:0] load_data;
   logic              start;
   logic              resend;
   logic              path_ready;
   logic              path_valid;
   logic [DATA_W-1:0] path;
   logic [DW-1:0]     day_idx;
   logic [PW-1:0]     pass_idx;
   logic              busy;
   logic              done;

   int checks   = 0;
   int failures = 0;

   logic [DATA_W-1:0] obs_val  [N_PATH];
   logic [DW-1:0]     obs_day  [N_PATH];
   logic [PW-1:0]     obs_pass [N_PATH];

   mc_path_feeder #(
      .DATA_W (DATA_W),
      .N_PATH (N_PATH),
      .N_DAY  (N_DAY),
      .N_PASS (N_PASS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_en    (load_en),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .start      (start),
      .resend     (resend),
      .path_ready (path_ready),
      .path_valid (path_valid),
      .path       (path),
      .day_idx    (day_idx),
      .pass_idx   (pass_idx),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_resend();
      resend = 1'b1;
      tick();
      resend = 1'b0;
   endtask

   // Records every accepted beat of one pass with path_ready held high; bounded wait.
   task automatic collect_pass(output int n);
      int cyc;
      cyc = 0;
      n = 0;
      path_ready = 1'b1;
      while (n < N_PATH && cyc < N_PATH + 16) begin
         if (path_valid) begin
            obs_val[n]  = path;
            obs_day[n]  = day_idx;
            obs_pass[n] = pass_idx;
            n++;
         end
         tick();
         cyc++;
      end
   endtask

   task automatic load_storage();
      load_en = 1'b1;
      for (int a = 0; a < N_PATH * N_DAY; a++) begin
         load_addr = AW'(a);
         load_data = DATA_W'(a);
         tick();
      end
      load_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      load_en = 1'b0; load_addr = '0; load_data = '0;
      start = 1'b0; resend = 1'b0; path_ready = 1'b0;
      repeat (2) tick();
      checks++; if (path_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b want 0", path_valid); end
      checks++; if (path !== '0) begin failures++; $display("[TB] FAIL reset_path: got %h want 000", path); end
      checks++; if (day_idx !== '0) begin failures++; $display("[TB] FAIL reset_day: got %0d want 0", day_idx); end
      checks++; if (pass_idx !== '0) begin failures++; $display("[TB] FAIL reset_pass: got %0d want 0", pass_idx); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b want 0", done); end
      rst_n = 1'b1;
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_after_release: busy got %b want 0", busy); end
   endtask

   task automatic test_first_pass();
      int n;
      start = 1'b1;
      path_ready = 1'b1;
      tick();
      start = 1'b0;
      checks++; if ({busy, path_valid} !== 2'b11) begin failures++; $display("[TB] FAIL start_latency: busy/valid got %b want 11", {busy, path_valid}); end
      checks++; if (path !== 12'h000) begin failures++; $display("[TB] FAIL first_sample: got %h want 000", path); end
      collect_pass(n);
      checks++; if (n != N_PATH) begin failures++; $display("[TB] FAIL first_beats: got %0d want %0d", n, N_PATH); end
      for (int i = 0; i < n; i++) begin
         checks++;
         if (obs_val[i] !== DATA_W'(i) || obs_day[i] !== 3'd0 || obs_pass[i] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL first_pass[%0d]: got %h d%0d p%0d want %h d0 p0", i, obs_val[i], obs_day[i], obs_pass[i], DATA_W'(i));
         end
      end
      checks++; if ({path_valid, busy} !== 2'b01 || path !== '0) begin failures++; $display("[TB] FAIL enter_wait: valid/busy %b path %h want 01 000", {path_valid, busy}, path); end
   endtask

   task automatic test_replay_and_advance();
      int n;
      tick();
      checks++; if (path_valid !== 1'b0) begin failures++; $display("[TB] FAIL wait_hold: valid got %b want 0", path_valid); end
      do_resend();
      checks++; if (path_valid !== 1'b1 || pass_idx !== 1'b1 || path !== 12'h000) begin failures++; $display("[TB] FAIL replay_turnaround: valid %b pass %0d path %h want 1 1 000", path_valid, pass_idx, path); end
      collect_pass(n);
      checks++; if (n != N_PATH) begin failures++; $display("[TB] FAIL replay_beats: got %0d want %0d", n, N_PATH); end
      for (int i = 0; i < n; i++) begin
         checks++;
         if (obs_val[i] !== DATA_W'(i) || obs_day[i] !== 3'd0 || obs_pass[i] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL replay[%0d]: got %h d%0d p%0d want %h d0 p1", i, obs_val[i], obs_day[i], obs_pass[i], DATA_W'(i));
         end
      end
      do_resend();
      checks++; if (day_idx !== 3'd1 || pass_idx !== 1'b0 || path !== 12'h100) begin failures++; $display("[TB] FAIL advance_day: d%0d p%0d path %h want d1 p0 100", day_idx, pass_idx, path); end
      collect_pass(n);
      checks++; if (n != N_PATH) begin failures++; $display("[TB] FAIL day1_beats: got %0d want %0d", n, N_PATH); end
      for (int i = 0; i < n; i++) begin
         checks++;
         if (obs_val[i] !== DATA_W'(256 + i) || obs_day[i] !== 3'd1 || obs_pass[i] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL day1[%0d]: got %h d%0d p%0d want %h d1 p0", i, obs_val[i], obs_day[i], obs_pass[i], DATA_W'(256 + i));
         end
      end
   endtask

   task automatic test_ignored_inputs();
      int n;
      int cyc;
      do_resend();
      n = 0;
      cyc = 0;
      path_ready = 1'b1;
      while (n < N_PATH && cyc < N_PATH + 16) begin
         if (n == 10) begin
            start = 1'b1; resend = 1'b1; load_en = 1'b1;
            load_addr = AW'(5); load_data = 12'hABC;
         end else begin
            start = 1'b0; resend = 1'b0; load_en = 1'b0;
         end
         if (path_valid) begin
            checks++;
            if (path !== DATA_W'(256 + n) || day_idx !== 3'd1 || pass_idx !== 1'b1) begin
               failures++;
               $display("[TB] FAIL ignored_stream[%0d]: got %h d%0d p%0d want %h d1 p1", n, path, day_idx, pass_idx, DATA_W'(256 + n));
            end
            n++;
         end
         tick();
         cyc++;
      end
      start = 1'b0; resend = 1'b0; load_en = 1'b0;
      checks++; if (n != N_PATH) begin failures++; $display("[TB] FAIL ignored_beats: got %0d want %0d", n, N_PATH); end
      repeat (3) tick();
      checks++; if (path_valid !== 1'b0 || busy !== 1'b1 || day_idx !== 3'd1 || pass_idx !== 1'b1) begin failures++; $display("[TB] FAIL no_extra_pass: valid %b busy %b d%0d p%0d want 0 1 d1 p1", path_valid, busy, day_idx, pass_idx); end
   endtask

   task automatic test_stall();
      int n;
      int cyc;
      logic stalled;
      logic [DATA_W-1:0] held;
      do_resend();
      n = 0;
      cyc = 0;
      stalled = 1'b0;
      held = '0;
      while (n < N_PATH && cyc < 3 * N_PATH + 16) begin
         path_ready = ((cyc % 3) == 0);
         if (stalled) begin
            checks++;
            if ({path_valid, path} !== {1'b1, held}) begin
               failures++;
               $display("[TB] FAIL stall_hold[%0d]: valid %b path %h want 1 %h", n, path_valid, path, held);
            end
         end
         if (path_valid) begin
            if (path_ready) begin
               checks++;
               if (path !== DATA_W'(512 + n)) begin
                  failures++;
                  $display("[TB] FAIL stall_order[%0d]: got %h want %h", n, path, DATA_W'(512 + n));
               end
               n++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held = path;
            end
         end
         tick();
         cyc++;
      end
      path_ready = 1'b1;
      checks++; if (n != N_PATH || path_valid !== 1'b0) begin failures++; $display("[TB] FAIL stall_beats: got %0d valid %b want %0d 0", n, path_valid, N_PATH); end
   endtask

   task automatic test_mid_reset();
      int n;
      do_resend();
      collect_pass(n);
      checks++; if (n != N_PATH || obs_val[N_PATH-1] !== 12'h2FF || obs_pass[0] !== 1'b1) begin failures++; $display("[TB] FAIL day2_pass1: beats %0d last %h pass %0d want 256 2ff 1", n, obs_val[N_PATH-1], obs_pass[0]); end
      tick();
      do_resend();
      path_ready = 1'b1;
      repeat (100) tick();
      checks++; if (path_valid !== 1'b1 || day_idx !== 3'd3 || path !== 12'h364) begin failures++; $display("[TB] FAIL before_abort: valid %b d%0d path %h want 1 d3 364", path_valid, day_idx, path); end
      rst_n = 1'b0;
      #1;
      checks++; if ({path_valid, busy, done} !== 3'b000 || path !== '0 || day_idx !== '0 || pass_idx !== '0) begin failures++; $display("[TB] FAIL abort_outputs: valid/busy/done %b path %h d%0d p%0d want 000 000 0 0", {path_valid, busy, done}, path, day_idx, pass_idx); end
      tick();
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL abort_no_done: got %b want 0", done); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_full_run();
      int n;
      int d;
      int p;
      start = 1'b1;
      path_ready = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (path_valid !== 1'b1 || path !== 12'h000) begin failures++; $display("[TB] FAIL restart_sample0: valid %b path %h want 1 000", path_valid, path); end
      for (int k = 0; k < N_DAY * N_PASS; k++) begin
         d = k / N_PASS;
         p = k % N_PASS;
         collect_pass(n);
         checks++; if (n != N_PATH) begin failures++; $display("[TB] FAIL run_beats[%0d]: got %0d want %0d", k, n, N_PATH); end
         for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_val[i] !== DATA_W'(d * N_PATH + i) || obs_day[i] !== DW'(d) || obs_pass[i] !== PW'(p)) begin
               failures++;
               $display("[TB] FAIL run[%0d][%0d]: got %h d%0d p%0d want %h d%0d p%0d", k, i, obs_val[i], obs_day[i], obs_pass[i], DATA_W'(d * N_PATH + i), d, p);
            end
         end
         repeat (2) begin
            checks++; if (done !== 1'b0 || path_valid !== 1'b0) begin failures++; $display("[TB] FAIL run_wait[%0d]: done %b valid %b want 0 0", k, done, path_valid); end
            tick();
         end
         do_resend();
         if (k < N_DAY * N_PASS - 1) begin
            checks++; if (path_valid !== 1'b1 || done !== 1'b0) begin failures++; $display("[TB] FAIL run_resume[%0d]: valid %b done %b want 1 0", k, path_valid, done); end
         end else begin
            checks++; if ({done, busy, path_valid} !== 3'b100 || day_idx !== '0 || pass_idx !== '0) begin failures++; $display("[TB] FAIL run_done: done/busy/valid %b d%0d p%0d want 100 d0 p0", {done, busy, path_valid}, day_idx, pass_idx); end
         end
      end
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL done_pulse_width: done %b busy %b want 0 0", done, busy); end
   endtask

   task automatic test_start_with_load();
      resend = 1'b1;
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL resend_in_idle: busy got %b want 0", busy); end
      start = 1'b1; load_en = 1'b1; load_addr = '0; load_data = 12'h5A5;
      tick();
      start = 1'b0; load_en = 1'b0; resend = 1'b0;
      checks++; if (path_valid !== 1'b1 || pass_idx !== 1'b0 || path !== 12'h5A5) begin failures++; $display("[TB] FAIL start_with_load: valid %b p%0d path %h want 1 p0 5a5", path_valid, pass_idx, path); end
      path_ready = 1'b1;
      tick();
      checks++; if (path !== 12'h001) begin failures++; $display("[TB] FAIL after_load_sample1: got %h want 001", path); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      load_storage();
      test_first_pass();
      test_replay_and_advance();
      test_ignored_inputs();
      test_stall();
      test_mid_reset();
      test_full_run();
      test_start_with_load();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
